// File: rtl/hyst_comp_real_pkg.sv
// ============================================================================
// Module      : hyst_comp_real_pkg
// Description : Shared fixed-point real math constants and helpers
//               (comparison opcodes, counter-width helper).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package hyst_comp_real_pkg;

  // Comparison opcodes understood by comp_real
  localparam logic [1:0] CMP_GT = 2'd0;
  localparam logic [1:0] CMP_LT = 2'd1;

  // Bits needed to hold any count in 0..max_count (never less than 1)
  function automatic int cnt_width(input int max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/hyst_comp_real_comp.sv
// ============================================================================
// Module      : comp_real
// Description : Combinational signed fixed-point comparator. Both operands
//               are sign-extended and shifted onto the finer of the two
//               exponents before comparing, so differing formats compare
//               by real value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comp_real
  import hyst_comp_real_pkg::*;
#(
  parameter int         A_WIDTH = 16,
  parameter int         A_EXP   = -8,
  parameter int         B_WIDTH = 16,
  parameter int         B_EXP   = -8,
  parameter logic [1:0] OP      = CMP_GT
) (
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  output logic               res_o
);

  // Common exponent is the smaller one: shifting left never loses bits
  localparam int C_EXP  = (A_EXP < B_EXP) ? A_EXP : B_EXP;
  localparam int C_A_SH = A_EXP - C_EXP;
  localparam int C_B_SH = B_EXP - C_EXP;
  localparam int C_A_AW = A_WIDTH + C_A_SH;
  localparam int C_B_AW = B_WIDTH + C_B_SH;
  localparam int C_W    = (C_A_AW > C_B_AW) ? C_A_AW : C_B_AW;

  logic signed [A_WIDTH-1:0] w_a_s;
  logic signed [B_WIDTH-1:0] w_b_s;
  logic signed [C_W-1:0]     w_a_al;
  logic signed [C_W-1:0]     w_b_al;

  assign w_a_s  = a_i;
  assign w_b_s  = b_i;
  assign w_a_al = C_W'(w_a_s) <<< C_A_SH;
  assign w_b_al = C_W'(w_b_s) <<< C_B_SH;

  // Strict comparison selected by opcode
  always_comb begin
    res_o = 1'b0;
    case (OP)
      CMP_GT:  res_o = (w_a_al > w_b_al);
      CMP_LT:  res_o = (w_a_al < w_b_al);
      default: res_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hyst_comp_real.sv
// ============================================================================
// Module      : hyst_comp_real
// Description : Debounced hysteresis (Schmitt) comparator for fixed-point
//               reals. In LOW it looks for in > th_hi, in HIGH for
//               in < th_lo; DEBOUNCE consecutive qualifying enabled cycles
//               flip the state and emit a one-cycle rise/fall pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hyst_comp_real
  import hyst_comp_real_pkg::*;
#(
  parameter int IN_WIDTH    = 16,
  parameter int IN_EXP      = -8,
  parameter int TH_HI_WIDTH = 16,
  parameter int TH_HI_EXP   = -8,
  parameter int TH_LO_WIDTH = 16,
  parameter int TH_LO_EXP   = -8,
  parameter int DEBOUNCE    = 1,
  parameter bit INIT        = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cke,
  input  logic [IN_WIDTH-1:0]    in,
  input  logic [TH_HI_WIDTH-1:0] th_hi,
  input  logic [TH_LO_WIDTH-1:0] th_lo,
  output logic                   out,
  output logic                   rise,
  output logic                   fall,
  output logic                   cfg_err
);

  localparam int             C_CNT_W    = cnt_width(DEBOUNCE);
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(DEBOUNCE - 1);

  // Reject illegal debounce lengths at elaboration
  generate
    if ((DEBOUNCE < 1) || (DEBOUNCE > 255)) begin : g_bad_debounce
      $error("hyst_comp_real: DEBOUNCE must be in 1..255");
    end
  endgenerate

  logic               w_gt_hi;
  logic               w_lt_lo;
  logic               w_inverted;
  logic               w_qual;

  logic               out_q,     out_d;
  logic [C_CNT_W-1:0] cnt_q,     cnt_d;
  logic               rise_q,    rise_d;
  logic               fall_q,    fall_d;
  logic               cfg_err_q, cfg_err_d;

  comp_real #(
    .A_WIDTH (IN_WIDTH),
    .A_EXP   (IN_EXP),
    .B_WIDTH (TH_HI_WIDTH),
    .B_EXP   (TH_HI_EXP),
    .OP      (CMP_GT)
  ) u_cmp_hi (
    .a_i   (in),
    .b_i   (th_hi),
    .res_o (w_gt_hi)
  );

  comp_real #(
    .A_WIDTH (IN_WIDTH),
    .A_EXP   (IN_EXP),
    .B_WIDTH (TH_LO_WIDTH),
    .B_EXP   (TH_LO_EXP),
    .OP      (CMP_LT)
  ) u_cmp_lo (
    .a_i   (in),
    .b_i   (th_lo),
    .res_o (w_lt_lo)
  );

  // th_lo above th_hi: hysteresis band is inverted
  comp_real #(
    .A_WIDTH (TH_LO_WIDTH),
    .A_EXP   (TH_LO_EXP),
    .B_WIDTH (TH_HI_WIDTH),
    .B_EXP   (TH_HI_EXP),
    .OP      (CMP_GT)
  ) u_cmp_cfg (
    .a_i   (th_lo),
    .b_i   (th_hi),
    .res_o (w_inverted)
  );

  // The comparison that matters depends on the current state
  assign w_qual = out_q ? w_lt_lo : w_gt_hi;

  // Next-state: debounce count, state flip and transition pulses
  always_comb begin
    out_d     = out_q;
    cnt_d     = cnt_q;
    rise_d    = 1'b0;
    fall_d    = 1'b0;
    cfg_err_d = cfg_err_q;
    if (cke) begin
      cfg_err_d = w_inverted;
      if (w_qual && (cnt_q == C_CNT_LAST)) begin
        out_d  = ~out_q;
        cnt_d  = '0;
        rise_d = ~out_q;
        fall_d = out_q;
      end else if (w_qual) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  // State registers; reset discards any partial debounce run
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q     <= INIT;
      cnt_q     <= '0;
      rise_q    <= 1'b0;
      fall_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      cnt_q     <= cnt_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  assign out     = out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign cfg_err = cfg_err_q;

endmodule

`default_nettype wire

// File: tb/tb_hyst_comp_real.sv
// ============================================================================
// Module      : tb_hyst_comp_real
// Description : Directed self-checking bench for hyst_comp_real. Four
//               instances share stimulus, each with the DEBOUNCE/INIT
//               setting one scenario needs. Values are Q8.8 (1.0 = 256).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hyst_comp_real;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cke = 1'b1;
  logic [15:0] in_s = 16'd0;
  logic [15:0] th_hi_s = 16'd256;
  logic [15:0] th_lo_s = 16'hFF00;

  logic out1, rise1, fall1, err1;
  logic out2, rise2, fall2, err2;
  logic out3, rise3, fall3, err3;
  logic out4, rise4, fall4, err4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hyst_comp_real #(.DEBOUNCE(1), .INIT(1'b0)) d1 (
    .clk(clk), .rst(rst), .cke(cke), .in(in_s), .th_hi(th_hi_s), .th_lo(th_lo_s),
    .out(out1), .rise(rise1), .fall(fall1), .cfg_err(err1));
  hyst_comp_real #(.DEBOUNCE(2), .INIT(1'b0)) d2 (
    .clk(clk), .rst(rst), .cke(cke), .in(in_s), .th_hi(th_hi_s), .th_lo(th_lo_s),
    .out(out2), .rise(rise2), .fall(fall2), .cfg_err(err2));
  hyst_comp_real #(.DEBOUNCE(3), .INIT(1'b0)) d3 (
    .clk(clk), .rst(rst), .cke(cke), .in(in_s), .th_hi(th_hi_s), .th_lo(th_lo_s),
    .out(out3), .rise(rise3), .fall(fall3), .cfg_err(err3));
  hyst_comp_real #(.DEBOUNCE(4), .INIT(1'b1)) d4 (
    .clk(clk), .rst(rst), .cke(cke), .in(in_s), .th_hi(th_hi_s), .th_lo(th_lo_s),
    .out(out4), .rise(rise4), .fall(fall4), .cfg_err(err4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset all instances with default thresholds +1.0 / -1.0
  task automatic apply_reset();
    cke = 1'b1;
    in_s = 16'd0;
    th_hi_s = 16'd256;
    th_lo_s = 16'hFF00;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (out1 !== 1'b0) begin errors++; $display("FAIL reset_out_init0 got %b exp 0", out1); end
    checks++; if (out4 !== 1'b1) begin errors++; $display("FAIL reset_out_init1 got %b exp 1", out4); end
    checks++; if ({rise1, fall1, rise4, fall4} !== 4'b0) begin errors++; $display("FAIL reset_pulses got %b exp 0000", {rise1, fall1, rise4, fall4}); end
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL reset_cfg_err got %b exp 0", err1); end
  endtask

  task automatic test_crossing();
    int v;
    logic exp_out, exp_rise, exp_fall;
    apply_reset();
    for (int i = -8; i <= 8; i++) begin
      v = i * 64;
      in_s = 16'(v);
      tick();
      exp_out = (v > 256);
      exp_rise = (v == 320);
      checks++; if (out1 !== exp_out) begin errors++; $display("FAIL ramp_up_out in=%0d got %b exp %b", v, out1, exp_out); end
      checks++; if (rise1 !== exp_rise) begin errors++; $display("FAIL ramp_up_rise in=%0d got %b exp %b", v, rise1, exp_rise); end
      checks++; if (fall1 !== 1'b0) begin errors++; $display("FAIL ramp_up_fall in=%0d got %b exp 0", v, fall1); end
    end
    for (int i = 8; i >= -8; i--) begin
      v = i * 64;
      in_s = 16'(v);
      tick();
      exp_out = (v >= -256);
      exp_fall = (v == -320);
      checks++; if (out1 !== exp_out) begin errors++; $display("FAIL ramp_dn_out in=%0d got %b exp %b", v, out1, exp_out); end
      checks++; if (fall1 !== exp_fall) begin errors++; $display("FAIL ramp_dn_fall in=%0d got %b exp %b", v, fall1, exp_fall); end
      checks++; if (rise1 !== 1'b0) begin errors++; $display("FAIL ramp_dn_rise in=%0d got %b exp 0", v, rise1); end
    end
  endtask

  task automatic test_debounce();
    logic [15:0] seq [6];
    logic        exp_out [6];
    int          exp_cnt [6];
    seq = '{16'd384, 16'd384, 16'd128, 16'd384, 16'd384, 16'd384};
    exp_out = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_cnt = '{1, 2, 0, 1, 2, 0};
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      in_s = seq[k];
      tick();
      checks++; if (out3 !== exp_out[k]) begin errors++; $display("FAIL debounce_out edge=%0d got %b exp %b", k + 1, out3, exp_out[k]); end
      checks++; if (int'(d3.cnt_q) != exp_cnt[k]) begin errors++; $display("FAIL debounce_cnt edge=%0d got %0d exp %0d", k + 1, d3.cnt_q, exp_cnt[k]); end
      checks++; if (rise3 !== (k == 5)) begin errors++; $display("FAIL debounce_rise edge=%0d got %b exp %b", k + 1, rise3, (k == 5)); end
    end
  endtask

  task automatic test_cke();
    apply_reset();
    in_s = 16'd384;
    cke = 1'b1;
    tick();
    checks++; if (out2 !== 1'b0) begin errors++; $display("FAIL cke_edge1_out got %b exp 0", out2); end
    cke = 1'b0;
    tick();
    checks++; if (out2 !== 1'b0) begin errors++; $display("FAIL cke_edge2_out got %b exp 0", out2); end
    checks++; if (rise2 !== 1'b0) begin errors++; $display("FAIL cke_edge2_rise got %b exp 0", rise2); end
    checks++; if (int'(d2.cnt_q) != 1) begin errors++; $display("FAIL cke_hold_cnt got %0d exp 1", d2.cnt_q); end
    cke = 1'b1;
    tick();
    checks++; if (out2 !== 1'b1) begin errors++; $display("FAIL cke_edge3_out got %b exp 1", out2); end
    checks++; if (rise2 !== 1'b1) begin errors++; $display("FAIL cke_edge3_rise got %b exp 1", rise2); end
    cke = 1'b0;
    tick();
    checks++; if (rise2 !== 1'b0) begin errors++; $display("FAIL cke_pulse_clear got %b exp 0", rise2); end
    checks++; if (out2 !== 1'b1) begin errors++; $display("FAIL cke_edge4_out got %b exp 1", out2); end
    cke = 1'b1;
  endtask

  task automatic test_async_reset();
    apply_reset();
    in_s = 16'hFE00;
    tick();
    tick();
    checks++; if (int'(d4.cnt_q) != 2) begin errors++; $display("FAIL arst_precount got %0d exp 2", d4.cnt_q); end
    #3;
    rst = 1'b1;
    #1;
    checks++; if (out4 !== 1'b1) begin errors++; $display("FAIL arst_out got %b exp 1", out4); end
    checks++; if ({rise4, fall4} !== 2'b00) begin errors++; $display("FAIL arst_pulses got %b exp 00", {rise4, fall4}); end
    checks++; if (int'(d4.cnt_q) != 0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", d4.cnt_q); end
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (out4 !== (k < 4)) begin errors++; $display("FAIL arst_after_out edge=%0d got %b exp %b", k, out4, (k < 4)); end
      checks++; if (fall4 !== (k == 4)) begin errors++; $display("FAIL arst_after_fall edge=%0d got %b exp %b", k, fall4, (k == 4)); end
    end
  endtask

  task automatic test_inverted();
    apply_reset();
    th_hi_s = 16'hFF00;
    th_lo_s = 16'd256;
    in_s = 16'd0;
    checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL inv_err_before got %b exp 0", err1); end
    for (int k = 1; k <= 4; k++) begin
      tick();
      checks++; if (err1 !== 1'b1) begin errors++; $display("FAIL inv_err edge=%0d got %b exp 1", k, err1); end
      checks++; if (out1 !== k[0]) begin errors++; $display("FAIL inv_out edge=%0d got %b exp %b", k, out1, k[0]); end
      checks++; if (rise1 !== k[0]) begin errors++; $display("FAIL inv_rise edge=%0d got %b exp %b", k, rise1, k[0]); end
      checks++; if (fall1 !== ~k[0]) begin errors++; $display("FAIL inv_fall edge=%0d got %b exp %b", k, fall1, ~k[0]); end
    end
    th_hi_s = 16'd0;
    th_lo_s = 16'd0;
    for (int k = 1; k <= 2; k++) begin
      tick();
      checks++; if (err1 !== 1'b0) begin errors++; $display("FAIL eq_err edge=%0d got %b exp 0", k, err1); end
      checks++; if ({out1, rise1, fall1} !== 3'b000) begin errors++; $display("FAIL eq_hold edge=%0d got %b exp 000", k, {out1, rise1, fall1}); end
    end
    in_s = 16'd1;
    tick();
    checks++; if ({out1, rise1} !== 2'b11) begin errors++; $display("FAIL eq_above got %b exp 11", {out1, rise1}); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    test_reset();
    test_crossing();
    test_debounce();
    test_cke();
    test_async_reset();
    test_inverted();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/hyst_comp_real.md
Name: hyst_comp_real

Overview:
- Sequential hysteresis (Schmitt) comparator for fixed-point reals.
- Owns and configures the comparison direction:
  - In state LOW it tests in > th_hi.
  - In state HIGH it tests in < th_lo.
- A debounce counter requires DEBOUNCE consecutive qualifying cycles before the state flips.
- Sits between analog-model outputs (ADC/plant signals) and digital control logic; replaces ad-hoc threshold registers.

Parameters:
- DECL_REAL(in): width/exponent/range of the input signal.
- DECL_REAL(th_hi): format of the upper threshold.
- DECL_REAL(th_lo): format of the lower threshold.
- DEBOUNCE, default 1: consecutive qualifying cycles needed to switch state; legal range 1..255, elaboration error otherwise.
- INIT, default 0: state and out value after reset (0=LOW, 1=HIGH).

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous, active-high reset.
- cke  input  1  clock enable; when low all state holds.
- in  input  WIDTH_PARAM_REAL(in)  signal under test.
- th_hi  input  WIDTH_PARAM_REAL(th_hi)  upper threshold (LOW->HIGH).
- th_lo  input  WIDTH_PARAM_REAL(th_lo)  lower threshold (HIGH->LOW).
- out  output  1  registered hysteresis state.
- rise  output  1  one-cycle pulse on the LOW->HIGH transition.
- fall  output  1  one-cycle pulse on the HIGH->LOW transition.
- cfg_err  output  1  registered; high while th_lo > th_hi.

Behaviour:
- Reset (async assert, sync release):
  - out=INIT, cnt=0, rise=0, fall=0, cfg_err=0.
  - Reset mid-debounce discards the partial count.
- Comparisons:
  - Combinational, with operands aligned to the max range of the two operands.
  - Strict inequalities: in == th_hi never qualifies in LOW; in == th_lo never qualifies in HIGH.
- qual = (state==LOW) ? (in > th_hi) : (in < th_lo).
- Each posedge with cke=1:
  - If qual and cnt == DEBOUNCE-1:
    - state toggles; cnt <= 0.
    - rise<=1 if the new state is HIGH, else fall<=1.
  - Else if qual: cnt <= cnt+1; rise=fall=0.
  - Else: cnt <= 0 (any non-qualifying cycle restarts debounce); rise=fall=0.
- Latency: with DEBOUNCE=1, out changes at the first posedge after in crosses. In general it changes on the DEBOUNCE-th consecutive qualifying edge.
- cke=0:
  - out, cnt and cfg_err hold.
  - rise and fall are forced 0 on that edge, so a pulse lasts exactly one enabled-or-not cycle.
- Counter:
  - Width clog2(DEBOUNCE+1).
  - Saturation is impossible because the transition clears it.
- Threshold changes during a debounce run:
  - Evaluated each cycle with current values.
  - If qual drops, cnt clears.
- cfg_err:
  - Registered (th_lo > th_hi) each enabled cycle.
  - The state machine still runs. With inverted thresholds, a value between them toggles every DEBOUNCE cycles; this is defined behaviour, flagged only.
- Both thresholds equal: legal; acts as a plain debounced comparator with a dead point at equality.
- Out-of-range inputs are the caller's responsibility (standard range assertions only).

Decomposition:
- Shared math/real package holds:
  - The opcode constants already used for comparisons (GT/LT).
  - A clog2-based counter-width helper.
- No new typedefs.
- Sub-module: comp_real, instantiated twice:
  - GT opcode on (in, th_hi).
  - LT opcode on (in, th_lo).
  - A third instance with GT on (th_lo, th_hi) produces cfg_err.
- State machine, counter and pulse logic live in hyst_comp_real.

Test Plan:
- Common setup: all formats width 16, exponent -8; DEBOUNCE=1, INIT=0; th_hi=1.0, th_lo=-1.0.
- Crossing up and down: ramp in from -2.0 to 2.0 in 0.25 steps, then back down.
  - out rises the edge after in=1.25 is applied, with rise high exactly 1 cycle.
  - out falls the edge after in=-1.25, with a single fall pulse.
  - in=1.0 and in=-1.0 cause no change.
- Debounce: DEBOUNCE=3, in alternates 1.5,1.5,0.5,1.5,1.5,1.5.
  - out stays 0 through the first glitch.
  - out goes high on the 6th edge; cnt observed clearing at the 0.5 sample.
- cke gating: DEBOUNCE=2, in=1.5, cke pattern 1,0,1.
  - out rises on the third edge.
  - No rise pulse emitted while cke=0.
- Async reset mid-operation: INIT=1, DEBOUNCE=4, in=-2.0.
  - Assert rst between clock edges after 2 qualifying cycles: out=1 and rise/fall=0 immediately, without waiting for a clock.
  - After release, out falls only after 4 more cycles.
- Inverted thresholds: th_hi=-1.0, th_lo=1.0, in=0.0.
  - cfg_err=1 one edge after configuration.
  - out toggles every cycle with alternating rise/fall pulses.
  - Setting th_lo=th_hi=0.0 clears cfg_err and stops toggling.
